seg_display_ctrl: RTL and testbench

- Memory-mapped eight-digit seven-segment display controller on the peripheral bus.
- Role: the consuming/output end of the peripheral path. The CPU writes a 32-bit value, and the block time-multiplexes its eight hex nibbles onto a common-anode display.
- Also provides register readback so software can read the displayed value and configuration.
- Sits beside the timer-counter peripheral and decodes its own base address (`PERI_ADDR_DIG`) from the shared address bus.

---
 rtl/seg_display_ctrl_pkg.sv | 16 +
 rtl/seg_display_ctrl_if.sv | 10 +
 rtl/seg_display_ctrl_hex_to_seg.sv | 31 +++
 rtl/seg_display_ctrl.sv | 102 ++++++++++
 tb/tb_seg_display_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// rtl/seg_display_ctrl_pkg.sv - shared address map and defaults for the seven-segment display controller
package seg_display_ctrl_pkg;

  localparam logic [31:0] PERI_ADDR_DIG      = 32'h8000_0020;
  localparam logic [3:0]  DIG_OFF_VALUE      = 4'h0;
  localparam logic [3:0]  DIG_OFF_MASK       = 4'h4;
  localparam logic [3:0]  DIG_OFF_DIV        = 4'h8;
  localparam logic [31:0] SCAN_DIV_DEFAULT   = 32'd49999;
  localparam int          NUM_DIGITS_DEFAULT = 8;

  // The low nibble of the bus address is the register offset inside the block.
  function automatic logic dig_selected(input logic [31:0] addr);
    return {addr[31:4], 4'b0000} == PERI_ADDR_DIG;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// rtl/seg_display_ctrl_if.sv - peripheral bus bundle between the CPU side and the display controller
interface seg_display_ctrl_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/seg_display_ctrl_hex_to_seg.sv
// rtl/seg_display_ctrl_hex_to_seg.sv - nibble to active-low {dp,g,f,e,d,c,b,a} segment code
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  // dp (bit 7) is held dark in every entry.
  always_comb begin
    seg = 8'hFF;
    case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - memory-mapped eight-digit multiplexed seven-segment display controller
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter logic [31:0] SCAN_DIV_RST = SCAN_DIV_DEFAULT,
  parameter int          NUM_DIGITS   = NUM_DIGITS_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  seg_display_ctrl_if.slave     bus,
  output logic [NUM_DIGITS-1:0] dig_en_o,
  output logic [7:0]            seg_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [31:0]           value_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [31:0]           div_q;
  logic [31:0]           presc_q;
  logic [IDX_W-1:0]      idx_q;
  logic [31:0]           data_q;

  logic        sel;
  logic [3:0]  off;
  logic        wr_value;
  logic        wr_mask;
  logic        wr_div;
  logic [31:0] rd_mux;
  logic [3:0]  cur_nibble;
  logic [7:0]  cur_seg;

  always_comb begin
    sel      = dig_selected(bus.addr);
    off      = bus.addr[3:0];
    wr_value = sel && bus.we && (off == DIG_OFF_VALUE);
    wr_mask  = sel && bus.we && (off == DIG_OFF_MASK);
    wr_div   = sel && bus.we && (off == DIG_OFF_DIV);
    rd_mux   = 32'h0;
    case (off)
      DIG_OFF_VALUE: rd_mux = value_q;
      DIG_OFF_MASK:  rd_mux = 32'(mask_q);
      DIG_OFF_DIV:   rd_mux = div_q;
      default:       rd_mux = 32'h0;
    endcase
    cur_nibble = value_q[{idx_q, 2'b00} +: 4];
  end

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q  <= 32'h0;
      mask_q   <= '1;
      div_q    <= SCAN_DIV_RST;
      presc_q  <= 32'h0;
      idx_q    <= '0;
      data_q   <= 32'h0;
      dig_en_o <= '1;
      seg_o    <= 8'hFF;
    end else begin
      // Read mux sees pre-write register contents, so read-during-write returns the old value.
      if (sel) begin
        data_q <= rd_mux;
      end

      if (wr_value) begin
        value_q <= bus.wdata;
      end
      if (wr_mask) begin
        mask_q <= bus.wdata[NUM_DIGITS-1:0];
      end
      if (wr_div) begin
        div_q <= bus.wdata;
      end

      // A divider write restarts the slot so a smaller div can never leave presc above it.
      if (wr_div) begin
        presc_q <= 32'h0;
      end else if (presc_q == div_q) begin
        presc_q <= 32'h0;
        idx_q   <= idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 32'd1;
      end

      if (mask_q[idx_q]) begin
        dig_en_o <= ~(NUM_DIGITS'(1) << idx_q);
        seg_o    <= cur_seg;
      end else begin
        dig_en_o <= '1;
        seg_o    <= 8'hFF;
      end
    end
  end

  assign bus.rdata = data_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - self-checking bench for seg_display_ctrl against a behavioural display model
module tb_seg_display_ctrl;
  import seg_display_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dig_en;
  logic [7:0] seg;

  seg_display_ctrl_if bus ();

  seg_display_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .dig_en_o (dig_en),
    .seg_o    (seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registers, a slot timer and the digit being lit.
  logic [7:0]  hex_tab [16];
  logic [31:0] m_value, m_div, m_cnt;
  logic [7:0]  m_mask;
  int          m_idx;
  logic [7:0]  e_dig, e_seg;
  logic [31:0] e_data;
  bit          m_valid = 0;

  initial begin
    hex_tab[0]  = 8'hC0; hex_tab[1]  = 8'hF9; hex_tab[2]  = 8'hA4; hex_tab[3]  = 8'hB0;
    hex_tab[4]  = 8'h99; hex_tab[5]  = 8'h92; hex_tab[6]  = 8'h82; hex_tab[7]  = 8'hF8;
    hex_tab[8]  = 8'h80; hex_tab[9]  = 8'h90; hex_tab[10] = 8'h88; hex_tab[11] = 8'h83;
    hex_tab[12] = 8'hC6; hex_tab[13] = 8'hA1; hex_tab[14] = 8'h86; hex_tab[15] = 8'h8E;
  end

  always @(posedge clk) begin
    bit          sel_m;
    int          o;
    logic [31:0] old_div;
    if (rst) begin
      m_value = 0; m_mask = 8'hFF; m_div = 32'd49999; m_cnt = 0; m_idx = 0;
      e_dig = 8'hFF; e_seg = 8'hFF; e_data = 0; m_valid = 1;
    end else if (m_valid) begin
      sel_m = (bus.addr >= PERI_ADDR_DIG) && (bus.addr < PERI_ADDR_DIG + 32'd16);
      o     = int'(bus.addr - PERI_ADDR_DIG);
      if (m_mask[m_idx]) begin
        e_dig = 8'hFF ^ (8'd1 << m_idx);
        e_seg = hex_tab[(m_value >> (4 * m_idx)) % 16];
      end else begin
        e_dig = 8'hFF;
        e_seg = 8'hFF;
      end
      if (sel_m) e_data = (o == 0) ? m_value : (o == 4) ? {24'h0, m_mask} : (o == 8) ? m_div : 32'h0;
      old_div = m_div;
      if (sel_m && bus.we) begin
        if (o == 0) m_value = bus.wdata;
        if (o == 4) m_mask  = bus.wdata[7:0];
        if (o == 8) m_div   = bus.wdata;
      end
      if (sel_m && bus.we && o == 8) m_cnt = 0;
      else if (m_cnt == old_div) begin m_cnt = 0; m_idx = (m_idx + 1) % 8; end
      else m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_dig_en", {24'h0, dig_en}, {24'h0, e_dig});
      chk("model_seg",    {24'h0, seg},    {24'h0, e_seg});
      chk("model_data",   bus.rdata,       e_data);
    end
  end

  localparam logic [31:0] IDLE = 32'h0000_0000;

  task automatic wr(input logic [3:0] o, input logic [31:0] d);
    @(posedge clk); #1;
    bus.we = 1'b1; bus.addr = PERI_ADDR_DIG + 32'(o); bus.wdata = d;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.addr = IDLE;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.we = 1'b0; bus.addr = a;
    @(posedge clk);
    @(negedge clk);
    d = bus.rdata;
  endtask

  logic [7:0]  lit_dig [8];
  logic [7:0]  lit_seg [8];
  logic [31:0] rv;
  int          guard, cyc, run, n_dark, n_fe, n_fb, n_c0;
  logic [7:0]  d0;

  initial begin
    rst = 1'b1; bus.we = 1'b0; bus.addr = IDLE; bus.wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_dig_en", {24'h0, dig_en}, 32'hFF);
    chk("reset_seg",    {24'h0, seg},    32'hFF);
    chk("reset_data",   bus.rdata,       32'h0);
    rd(PERI_ADDR_DIG + 32'h8, rv); chk("reset_div",  rv, 32'd49999);
    rd(PERI_ADDR_DIG + 32'h4, rv); chk("reset_mask", rv, 32'h0000_00FF);

    // Full-speed scan of 89ABCDEF.
    lit_dig = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    lit_seg = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    wr(4'h8, 32'd0);
    wr(4'h0, 32'h89AB_CDEF);
    guard = 0;
    do begin @(negedge clk); guard++; end while (dig_en != 8'hFE && guard < 20);
    if (guard >= 20) chk("scan_start_timeout", 0, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      chk("scan_dig_en", {24'h0, dig_en}, {24'h0, lit_dig[i % 8]});
      chk("scan_seg",    {24'h0, seg},    {24'h0, lit_seg[i % 8]});
    end

    // DIV=3: every digit occupies four cycles.
    wr(4'h8, 32'd3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); d0 = dig_en; guard = 0;
      do begin @(negedge clk); guard++; end while (dig_en == d0 && guard < 20);
      d0 = dig_en; run = 1;
      do begin @(negedge clk); run++; end while (dig_en == d0 && run < 20);
      chk("div3_run_len", run - 1, 4);
    end

    // Shrink DIV to 1 while the prescaler sits at 3.
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (m_cnt != 3 && guard < 20);
    if (guard >= 20) chk("presc3_timeout", 0, 1);
    bus.we = 1'b1; bus.addr = PERI_ADDR_DIG + 32'h8; bus.wdata = 32'd1;
    @(posedge clk); #1; bus.we = 1'b0; bus.addr = IDLE;
    @(negedge clk); d0 = dig_en; cyc = 0;
    do begin @(negedge clk); cyc++; end while (dig_en == d0 && cyc < 20);
    chk("div_shrink_advance", cyc, 3);

    // Masked digits stay dark.
    wr(4'h8, 32'd0);
    wr(4'h0, 32'd0);
    wr(4'h4, 32'h5);
    @(negedge clk); @(negedge clk);
    n_dark = 0; n_fe = 0; n_fb = 0; n_c0 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (dig_en == 8'hFF && seg == 8'hFF) n_dark++;
      if (dig_en == 8'hFE) n_fe++;
      if (dig_en == 8'hFB) n_fb++;
      if (dig_en != 8'hFF && seg == 8'hC0) n_c0++;
    end
    chk("mask_dark", n_dark, 12);
    chk("mask_d0",   n_fe,   2);
    chk("mask_d2",   n_fb,   2);
    chk("mask_c0",   n_c0,   4);

    // Readback and read-during-write.
    wr(4'h0, 32'd1);
    rd(PERI_ADDR_DIG, rv);                 chk("read_value", rv, 32'h1);
    @(posedge clk); #1; bus.we = 1'b1; bus.wdata = 32'd2;
    @(posedge clk); #1; bus.we = 1'b0;
    @(negedge clk); chk("rdw_old", bus.rdata, 32'h1);
    @(negedge clk); chk("rdw_new", bus.rdata, 32'h2);
    wr(4'h4, 32'hFFFF_FF0F);
    rd(PERI_ADDR_DIG + 32'h4, rv);         chk("read_mask",  rv, 32'h0000_000F);
    rd(PERI_ADDR_DIG + 32'hC, rv);         chk("read_0xc",   rv, 32'h0);
    rd(PERI_ADDR_DIG + 32'h2, rv);         chk("read_unal",  rv, 32'h0);
    rd(PERI_ADDR_DIG, rv);                 chk("read_value2", rv, 32'h2);

    // Outside the block: nothing changes and data_o holds.
    @(posedge clk); #1; bus.we = 1'b1; bus.addr = PERI_ADDR_DIG + 32'h10; bus.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; bus.we = 1'b0;
    @(negedge clk); chk("outside_hold", bus.rdata, 32'h2);
    rd(PERI_ADDR_DIG, rv);                 chk("outside_nowrite", rv, 32'h2);

    // Reset in the middle of a scan at digit 5.
    wr(4'h4, 32'hFF);
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (m_idx != 5 && guard < 20);
    if (guard >= 20) chk("idx5_timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_dig_en", {24'h0, dig_en}, 32'hFF);
    chk("midrst_seg",    {24'h0, seg},    32'hFF);
    chk("midrst_data",   bus.rdata,       32'h0);
    @(negedge clk);
    chk("midrst_idx0",   {24'h0, dig_en}, 32'hFE);
    chk("midrst_seg0",   {24'h0, seg},    32'hC0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      rst    = ($urandom_range(0, 149) == 0);
      bus.we = $urandom_range(0, 1);
      case ($urandom_range(0, 6))
        0: bus.addr = PERI_ADDR_DIG;
        1: bus.addr = PERI_ADDR_DIG + 32'h4;
        2: bus.addr = PERI_ADDR_DIG + 32'h8;
        3: bus.addr = PERI_ADDR_DIG + 32'hC;
        4: bus.addr = PERI_ADDR_DIG + 32'($urandom_range(1, 15));
        5: bus.addr = PERI_ADDR_DIG + 32'h10;
        default: bus.addr = $urandom;
      endcase
      bus.wdata = (bus.addr == PERI_ADDR_DIG + 32'h8) ? 32'($urandom_range(0, 5)) : $urandom;
    end
    @(posedge clk); #1; rst = 1'b0; bus.we = 1'b0; bus.addr = IDLE;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
